// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the RS485 frame receiver and its transmitter peer:
// error codes, receiver FSM states and the common frame length.
package uart_rx_frame_pkg;

  localparam int DEF_FRAME_BYTES = 20;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FRAME = 2'd1;
  localparam logic [1:0] ERR_GAP   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial input and frame-buffer write port of the receiver.
interface uart_rx_frame_if #(
  parameter int AW = 5
);
  logic          rx;
  logic [7:0]    wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          frame_done;
  logic          frame_err;
  logic [1:0]    err_code;
  logic          busy;

  modport master (
    input  rx,
    output wr_data, wr_addr, wr_en, frame_done, frame_err, err_code, busy
  );

  modport slave (
    output rx,
    input  wr_data, wr_addr, wr_en, frame_done, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_rx_frame_sync2.sv
// Two-flop synchronizer with a selectable reset value, so an idle-high line
// does not look like a start bit coming out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (!reset) ff_q <= {2{RST_VAL}};
    else        ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling 8N1 receiver that writes bytes into a frame buffer, flags
// frame completion and aborts on a low stop bit or an over-long gap.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int OVS         = 4,
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int GAP_BITS    = 30
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_frame_if.master bus
);
  localparam int CW      = $clog2(OVS);
  localparam int GAP_LIM = GAP_BITS * OVS;
  localparam int GW      = $clog2(GAP_LIM + 1);
  localparam int AW      = $clog2(FRAME_BYTES);

  localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVS - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_LIM - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(FRAME_BYTES - 1);

  logic rx_s;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.rx),
    .q_o   (rx_s)
  );

  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [AW-1:0] idx_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    wr_data_q;
  logic [AW-1:0] wr_addr_q;
  logic          wr_en_q, done_q, err_q, busy_q;
  logic [1:0]    code_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // Gap timer only matters inside a partially received frame.
          if (idx_q != '0) begin
            if (gap_q == GAP_END) begin
              err_q  <= 1'b1;
              code_q <= ERR_GAP;
              idx_q  <= '0;
              gap_q  <= '0;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          if (!rx_s) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_DATA;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q          <= '0;
            shift_q[bit_q] <= rx_s;
            bit_q          <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            if (rx_s) begin
              state_q   <= ST_IDLE;
              wr_en_q   <= 1'b1;
              wr_data_q <= shift_q;
              wr_addr_q <= idx_q;
              if (idx_q == IDX_LAST) begin
                done_q <= 1'b1;
                idx_q  <= '0;
              end else begin
                idx_q <= idx_q + AW'(1);
              end
            end else begin
              state_q <= ST_BREAK;
              err_q   <= 1'b1;
              code_q  <= ERR_FRAME;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_BREAK: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.wr_data    = wr_data_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.err_code   = code_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Receive-side counterpart of the RS485 frame transmitter. Recovers 8N1 bytes from the RS485 receive line by oversampling. Writes each valid byte into a frame buffer at an auto-incrementing address, and pulses a completion flag when a full frame of FRAME_BYTES bytes has arrived. Framing errors and inter-byte gaps abort the frame and report an error code.

## Interface
- OVS, 4: clock cycles per bit; even, ≥4.
- FRAME_BYTES, 20: bytes per frame; matches transmitter frame length.
- GAP_BITS, 30: maximum idle bit-times between bytes inside a frame before abort.
- clk  in  1  oversampling clock, OVS × baud rate.
- reset  in  1  active-low, synchronous reset; one clock domain only.
- rx  in  1  serial line from RS485 transceiver; asynchronous; idle high.
- wr_data  out  8  received byte, LSB first on the line; reset 0.
- wr_addr  out  5  byte index in frame, 0..FRAME_BYTES-1; reset 0.
- wr_en  out  1  one-cycle write strobe; reset 0.
- frame_done  out  1  one-cycle pulse with the write of the last byte; reset 0.
- frame_err  out  1  one-cycle error pulse; reset 0.
- err_code  out  2  0 none, 1 framing (stop bit low), 2 gap timeout; holds until next error or reset; reset 0.
- busy  out  1  high while in START/DATA/STOP; reset 0.

## Operation
- rx passes through a 2-flop synchronizer (preset high at reset). The FSM uses only the synchronized bit rx_s.
- States:
  - IDLE: if rx_s==0, go to START with bit counter=0.
  - START: at cnt==OVS/2-1, re-check rx_s. If 1, treat as a glitch: return to IDLE with no outputs. If 0, go to DATA with cnt=0 and bit index=0.
  - DATA: at cnt==OVS-1, shift rx_s into bit[index] and reset cnt. After the 8th sample, go to STOP.
  - STOP: at cnt==OVS-1, sample the stop bit.
    - If 1: wr_data=shift register, wr_addr=byte index, wr_en=1. If the index was FRAME_BYTES-1, also assert frame_done and set index=0; otherwise increment the index. Return to IDLE.
    - If 0: discard the byte, assert frame_err, set err_code=1, set index=0, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A line held low produces no further bytes or errors.
- Gap timer:
  - Runs in IDLE only while the byte index≠0.
  - Clears on entry to START.
  - On reaching GAP_BITS*OVS clocks: frame_err=1, err_code=2, index=0. Fires once per partial frame.
- wr_addr holds the last written index between strobes.
- Reset mid-byte or mid-frame: all state returns to reset values at the next clk edge. Any partial byte or frame is lost silently.
- Simultaneous events: frame_done and frame_err are never high together. A timeout cannot coincide with a stop-bit sample, because the timer is stopped outside IDLE.

## Timing
- Let t0 be the clk edge at which the synchronizer's first flop captures the start-bit low. The FSM enters START at edge t0+2.
- The start-bit check occurs at edge t0+2+OVS/2.
- Data bit k (k=0..7) is sampled at edge t0+2+OVS/2+(k+1)·OVS, i.e. mid-bit.
- Stop-bit sample, wr_en, and frame_done are registered at edge t0+2+OVS/2+9·OVS. With OVS=4 they are high during the cycle after edge t0+40.
- The next start bit is accepted from the cycle after the STOP sample. This tolerates a transmitter stop bit of exactly one bit-time.
- All outputs are registered. Pulses last exactly one clk cycle.

## Structure
- Shared package: error-code constants (ERR_NONE=0, ERR_FRAME=1, ERR_GAP=2), the FSM state enum, and the default FRAME_BYTES=20 shared with the transmitter.
- One natural sub-module, sync2: a 2-flop synchronizer with a reset preset value parameter. It can be reused for the transmitter's request input.
- Counter widths derive from $clog2(OVS), $clog2(GAP_BITS*OVS+1), and $clog2(FRAME_BYTES).

## Test plan
- Single byte 0xA5 (8N1, OVS=4) -> one wr_en with wr_data=0xA5, wr_addr=0, at t0+40. frame_done=0 and frame_err=0.
- Transmitter-style frame of 20 back-to-back bytes (cnt, 10, 20, …, 190) -> 20 strobes with wr_addr 0..19 carrying those values. frame_done pulses with the addr-19 strobe. The index then returns to 0.
- Start glitch: rx low for 1 clk -> no wr_en, no error, FSM back in IDLE.
- Stop bit forced low on byte 3 -> no wr_en for that byte, frame_err pulse with err_code=1. After rx returns high, the next byte is written at wr_addr=0.
- 5 bytes, then rx held high for 30·4 clk -> frame_err with err_code=2 exactly at timer expiry. Subsequent bytes restart at wr_addr=0.
- reset asserted low for 1 clk during data bit 4 of byte 7 -> all outputs zero next cycle, no strobe for the partial byte. The next complete byte is written at wr_addr=0.
